// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor
// cell plus a borrow flip-flop. Start/busy/done handshake; the result and
// final borrow are held on diff/borrow_out until the next result.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] d_sr_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             brw_reg;
    logic             borrow_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             d_bit;
    logic             brw_bit;
    logic             last_bit;

    assign last_bit = (cnt_reg == LAST_CNT);

    // Full-subtractor cell on the current LSBs and the stored borrow.
    always_comb begin
        d_bit   = a_sr_reg[0] ^ b_sr_reg[0] ^ brw_reg;
        brw_bit = (~a_sr_reg[0] & b_sr_reg[0]) |
                  (~(a_sr_reg[0] ^ b_sr_reg[0]) & brw_reg);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start is only looked at in IDLE, so it is ignored while busy.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_SHIFT;
            S_SHIFT: if (last_bit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = (state_reg == S_SHIFT) || (state_reg == S_DONE);
        done = (state_reg == S_DONE);
    end

    // Datapath: capture on accept, shift one bit per SHIFT cycle. The result
    // register is loaded on the final shift (including that cycle's bit) so
    // diff/borrow_out are already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            d_sr_reg   <= '0;
            diff_reg   <= '0;
            brw_reg    <= 1'b0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_sr_reg <= a;
                        b_sr_reg <= b;
                        brw_reg  <= bin;
                        cnt_reg  <= '0;
                    end
                end
                S_SHIFT: begin
                    d_sr_reg <= {d_bit, d_sr_reg[WIDTH-1:1]};
                    a_sr_reg <= {1'b0, a_sr_reg[WIDTH-1:1]};
                    b_sr_reg <= {1'b0, b_sr_reg[WIDTH-1:1]};
                    brw_reg  <= brw_bit;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (last_bit) begin
                        diff_reg   <= {d_bit, d_sr_reg[WIDTH-1:1]};
                        borrow_reg <= brw_bit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench. Stimulus pushes expected
// {borrow_out,diff} into a queue; a monitor pops and compares on every done.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int checks;
    int errors;
    int n_exp;
    int n_done;
    int cyc;
    int last_done_cyc;
    bit b2b;
    bit prev_valid;

    logic [W:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got=%h/%h required=no done", borrow_out, diff);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({borrow_out, diff} !== e) begin
                    errors++;
                    $display("FAIL result got borrow=%0b diff=%h required borrow=%0b diff=%h",
                             borrow_out, diff, e[W], e[W-1:0]);
                end else begin
                    $display("done: borrow=%0b diff=%h ok", borrow_out, diff);
                end
            end
            if (b2b) begin
                if (prev_valid) begin
                    checks++;
                    if (cyc - last_done_cyc != W + 2) begin
                        errors++;
                        $display("FAIL done_spacing got=%0d required=%0d", cyc - last_done_cyc, W + 2);
                    end
                end
                prev_valid = 1'b1;
            end
            last_done_cyc = cyc;
        end
    end

    task automatic check1(input string name, input logic [W:0] got, input logic [W:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Single operation with start pulsed for one cycle; optionally check latency.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                          input logic [W:0] expv, input bit chk_lat);
        int lat;
        @(negedge clk);
        a = va; b = vb; bin = vbin; start = 1'b1;
        exp_q.push_back(expv);
        n_exp++;
        $display("issue a=%h b=%h bin=%0b expect=%h", va, vb, vbin, expv);
        @(negedge clk);
        start = 1'b0;
        a = ~va; b = ~vb; bin = ~vbin;   // operands may change after acceptance
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (chk_lat) check1("latency", (W+1)'(lat), (W+1)'(W + 1));
        else if (lat >= 40) check1("done_timeout", (W+1)'(lat), (W+1)'(0));
        @(negedge clk);
    endtask

    initial begin
        int t;
        checks = 0; errors = 0; n_exp = 0; n_done = 0; cyc = 0;
        last_done_cyc = 0; b2b = 1'b0; prev_valid = 1'b0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        check1("reset_busy", (W+1)'(busy), '0);
        check1("reset_done", (W+1)'(done), '0);
        check1("reset_result", {borrow_out, diff}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-computed results.
        run_op(8'h05, 8'h03, 1'b0, 9'h002, 1'b1);
        run_op(8'h03, 8'h05, 1'b0, 9'h1FE, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 9'h1FF, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 9'h0FE, 1'b0);
        run_op(8'h80, 8'h7F, 1'b1, 9'h000, 1'b0);

        // Start during SHIFT with new operands: must be ignored.
        @(negedge clk);
        a = 8'hA5; b = 8'h5A; bin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h04B);
        n_exp++;
        $display("issue a=a5 b=5a bin=0 expect=04b (start re-asserted while busy)");
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h11; b = 8'h22; bin = 1'b1; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check1("busy_in_shift", (W+1)'(busy), (W+1)'(1));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (15) @(negedge clk);
        check1("idle_after_ignore", (W+1)'(busy), '0);

        // Reset in the middle of an operation: aborts with no done pulse.
        @(negedge clk);
        a = 8'h3C; b = 8'h0F; bin = 1'b0; start = 1'b1;
        $display("issue a=3c b=0f bin=0 (to be aborted by reset)");
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check1("abort_busy", (W+1)'(busy), '0);
        check1("abort_done", (W+1)'(done), '0);
        check1("abort_result", {borrow_out, diff}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check1("abort_idle", (W+1)'(busy), '0);
        run_op(8'h10, 8'h01, 1'b1, 9'h00E, 1'b1);

        // Back-to-back random operations with start held high.
        b2b = 1'b1;
        prev_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            logic rbin;
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom);
            a = ra; b = rb; bin = rbin; start = 1'b1;
            exp_q.push_back({1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin});
            n_exp++;
            t = 0;
            while (busy && t < 50) begin @(negedge clk); t++; end
            t = 0;
            while (!busy && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) begin
                check1("accept_timeout", (W+1)'(t), '0);
                break;
            end
        end
        start = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        b2b = 1'b0;

        check1("queue_drained", (W+1)'(exp_q.size()), '0);
        checks++;
        if (n_done != n_exp) begin
            errors++;
            $display("FAIL done_count got=%0d required=%0d", n_done, n_exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
